// File: rtl/pipe_regfile_sb.sv
// GPR file for the pipelined core: two bypassed async read ports, one sync write port,
// per-register pending scoreboard and EPC/Cause exception state.
module pipe_regfile_sb #(
    parameter int WIDTH      = 32,
    parameter int AWIDTH     = 5,
    parameter int INIT_INDEX = 1,
    parameter int BYPASS     = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [AWIDTH-1:0] RAddrA,
    input  logic [AWIDTH-1:0] RAddrB,
    output logic [WIDTH-1:0]  RDataA,
    output logic [WIDTH-1:0]  RDataB,
    output logic              RPendA,
    output logic              RPendB,
    input  logic              WEn,
    input  logic [AWIDTH-1:0] WAddr,
    input  logic [WIDTH-1:0]  WData,
    input  logic              IssueEn,
    input  logic [AWIDTH-1:0] IssueAddr,
    input  logic              ExcEn,
    input  logic [WIDTH-1:0]  ExcPC,
    input  logic [4:0]        ExcCause,
    input  logic              EretEn,
    output logic [WIDTH-1:0]  EPC,
    output logic [WIDTH-1:0]  Cause,
    output logic              ExcActive
);

    localparam int DEPTH = 2 ** AWIDTH;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] HANDLER = 1'b1;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [0:0]       state;
    logic [WIDTH-1:0] epc;
    logic [4:0]       exccode;

    logic             wlive;
    logic             hitA;
    logic             hitB;

    assign wlive = WEn && (WAddr != '0);
    assign hitA  = wlive && (WAddr == RAddrA);
    assign hitB  = wlive && (WAddr == RAddrB);

    // Register 0 is kept at its reset value and masked on read, so it never changes.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (INIT_INDEX != 0 && i != 0) ? WIDTH'(i) : '0;
            end
        end else if (wlive) begin
            regs[WAddr] <= WData;
        end
    end

    // Issue sets the pending bit and wins over a same-edge writeback clear.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pend <= '0;
        end else begin
            pend[0] <= 1'b0;
            for (int r = 1; r < DEPTH; r++) begin
                if (IssueEn && IssueAddr == AWIDTH'(r)) begin
                    pend[r] <= 1'b1;
                end else if (WEn && WAddr == AWIDTH'(r)) begin
                    pend[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        RDataA = '0;
        RDataB = '0;
        RPendA = 1'b0;
        RPendB = 1'b0;
        if (RAddrA != '0) begin
            RDataA = (BYPASS != 0 && hitA) ? WData : regs[RAddrA];
            RPendA = pend[RAddrA] && !(BYPASS != 0 && hitA);
        end
        if (RAddrB != '0) begin
            RDataB = (BYPASS != 0 && hitB) ? WData : regs[RAddrB];
            RPendB = pend[RAddrB] && !(BYPASS != 0 && hitB);
        end
    end

    // A fault arriving together with ERET re-enters the handler with the new PC.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            epc     <= '0;
            exccode <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ExcEn) begin
                        state   <= HANDLER;
                        epc     <= ExcPC;
                        exccode <= ExcCause;
                    end
                end
                HANDLER: begin
                    if (ExcEn && EretEn) begin
                        epc     <= ExcPC;
                        exccode <= ExcCause;
                    end else if (EretEn) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign EPC       = epc;
    assign Cause     = {{(WIDTH-7){1'b0}}, exccode, 2'b00};
    assign ExcActive = (state == HANDLER);

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Directed testbench for pipe_regfile_sb: reads, bypass, scoreboard, exception FSM, async reset.
module tb_pipe_regfile_sb;

    logic        CLK;
    logic        RSTn;
    logic [4:0]  RAddrA, RAddrB;
    logic [31:0] RDataA, RDataB;
    logic        RPendA, RPendB;
    logic        WEn;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic        IssueEn;
    logic [4:0]  IssueAddr;
    logic        ExcEn;
    logic [31:0] ExcPC;
    logic [4:0]  ExcCause;
    logic        EretEn;
    logic [31:0] EPC, Cause;
    logic        ExcActive;

    int checks = 0;
    int errors = 0;

    pipe_regfile_sb #(.WIDTH(32), .AWIDTH(5), .INIT_INDEX(1), .BYPASS(1)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .RAddrA(RAddrA), .RAddrB(RAddrB),
        .RDataA(RDataA), .RDataB(RDataB),
        .RPendA(RPendA), .RPendB(RPendB),
        .WEn(WEn), .WAddr(WAddr), .WData(WData),
        .IssueEn(IssueEn), .IssueAddr(IssueAddr),
        .ExcEn(ExcEn), .ExcPC(ExcPC), .ExcCause(ExcCause), .EretEn(EretEn),
        .EPC(EPC), .Cause(Cause), .ExcActive(ExcActive)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive after the falling edge, let it settle through one rising edge, then quiesce strobes.
    task automatic clockAndClear();
        @(posedge CLK);
        #1;
        WEn     = 1'b0;
        IssueEn = 1'b0;
        ExcEn   = 1'b0;
        EretEn  = 1'b0;
        #1;
    endtask

    initial begin
        RSTn = 1'b0; RAddrA = '0; RAddrB = '0;
        WEn = 1'b0; WAddr = '0; WData = '0;
        IssueEn = 1'b0; IssueAddr = '0;
        ExcEn = 1'b0; ExcPC = '0; ExcCause = '0; EretEn = 1'b0;
        #23;
        RSTn = 1'b1;

        // Reset state
        RAddrA = 5'd7; RAddrB = 5'd31;
        #1;
        checkOutput("rst_rdA", RDataA, 32'd7);
        checkOutput("rst_rdB", RDataB, 32'd31);
        checkOutput("rst_pendA", {31'b0, RPendA}, 32'd0);
        checkOutput("rst_pendB", {31'b0, RPendB}, 32'd0);
        checkOutput("rst_epc", EPC, 32'd0);
        checkOutput("rst_cause", Cause, 32'd0);
        checkOutput("rst_active", {31'b0, ExcActive}, 32'd0);

        // Write with bypass
        @(negedge CLK);
        WEn = 1'b1; WAddr = 5'd5; WData = 32'hDEADBEEF; RAddrA = 5'd5; RAddrB = 5'd6;
        #1;
        checkOutput("byp_rdA", RDataA, 32'hDEADBEEF);
        checkOutput("byp_rdB_other", RDataB, 32'd6);
        clockAndClear();
        checkOutput("wr_rdA_held", RDataA, 32'hDEADBEEF);

        // Writes to register 0 are ignored
        @(negedge CLK);
        WEn = 1'b1; WAddr = 5'd0; WData = 32'h12345678; RAddrA = 5'd0;
        #1;
        checkOutput("r0_byp", RDataA, 32'd0);
        clockAndClear();
        checkOutput("r0_after", RDataA, 32'd0);

        // Scoreboard set, then forwarded clear on writeback
        @(negedge CLK);
        IssueEn = 1'b1; IssueAddr = 5'd9; RAddrA = 5'd9; RAddrB = 5'd9;
        #1;
        checkOutput("pend_before", {31'b0, RPendA}, 32'd0);
        clockAndClear();
        checkOutput("pend_setA", {31'b0, RPendA}, 32'd1);
        checkOutput("pend_setB", {31'b0, RPendB}, 32'd1);
        @(negedge CLK);
        WEn = 1'b1; WAddr = 5'd9; WData = 32'h99;
        #1;
        checkOutput("pend_fwd_clr", {31'b0, RPendA}, 32'd0);
        checkOutput("pend_fwd_data", RDataA, 32'h99);
        clockAndClear();
        checkOutput("pend_clr", {31'b0, RPendA}, 32'd0);
        checkOutput("pend_clr_data", RDataA, 32'h99);

        // Issue and writeback to the same register on one edge: set wins
        @(negedge CLK);
        IssueEn = 1'b1; IssueAddr = 5'd9; WEn = 1'b1; WAddr = 5'd9; WData = 32'hAA;
        clockAndClear();
        checkOutput("pend_setwins", {31'b0, RPendA}, 32'd1);
        checkOutput("pend_setwins_data", RDataA, 32'hAA);

        // Issue to register 0 never pends; issue to 12 stays pending
        @(negedge CLK);
        IssueEn = 1'b1; IssueAddr = 5'd0; RAddrB = 5'd0;
        clockAndClear();
        checkOutput("pend_r0", {31'b0, RPendB}, 32'd0);
        @(negedge CLK);
        IssueEn = 1'b1; IssueAddr = 5'd12; RAddrB = 5'd12;
        clockAndClear();
        checkOutput("pend_r12", {31'b0, RPendB}, 32'd1);

        // ERET while idle is ignored
        @(negedge CLK);
        EretEn = 1'b1;
        clockAndClear();
        checkOutput("eret_idle", {31'b0, ExcActive}, 32'd0);

        // Exception entry
        @(negedge CLK);
        ExcEn = 1'b1; ExcPC = 32'h00400010; ExcCause = 5'd12;
        clockAndClear();
        checkOutput("exc_epc", EPC, 32'h00400010);
        checkOutput("exc_cause", Cause, 32'h30);
        checkOutput("exc_active", {31'b0, ExcActive}, 32'd1);

        // Nested exception ignored
        @(negedge CLK);
        ExcEn = 1'b1; ExcPC = 32'h00500000; ExcCause = 5'd3;
        clockAndClear();
        checkOutput("nest_epc", EPC, 32'h00400010);
        checkOutput("nest_cause", Cause, 32'h30);
        checkOutput("nest_active", {31'b0, ExcActive}, 32'd1);

        // Return
        @(negedge CLK);
        EretEn = 1'b1;
        clockAndClear();
        checkOutput("eret_active", {31'b0, ExcActive}, 32'd0);
        checkOutput("eret_epc_hold", EPC, 32'h00400010);

        // Re-enter, then back-to-back fault on return
        @(negedge CLK);
        ExcEn = 1'b1; ExcPC = 32'h00700000; ExcCause = 5'd4;
        clockAndClear();
        checkOutput("reenter_epc", EPC, 32'h00700000);
        checkOutput("reenter_cause", Cause, 32'h10);
        @(negedge CLK);
        ExcEn = 1'b1; EretEn = 1'b1; ExcPC = 32'h00600000; ExcCause = 5'd5;
        clockAndClear();
        checkOutput("b2b_active", {31'b0, ExcActive}, 32'd1);
        checkOutput("b2b_epc", EPC, 32'h00600000);
        checkOutput("b2b_cause", Cause, 32'h14);

        // Exception state does not block register writes
        @(negedge CLK);
        WEn = 1'b1; WAddr = 5'd20; WData = 32'hCAFE0020; RAddrA = 5'd20;
        clockAndClear();
        checkOutput("exc_nowblock", RDataA, 32'hCAFE0020);

        // Asynchronous reset mid-cycle
        RAddrA = 5'd5; RAddrB = 5'd9;
        @(posedge CLK);
        #3;
        checkOutput("pre_rst_r5", RDataA, 32'hDEADBEEF);
        RSTn = 1'b0;
        #1;
        checkOutput("arst_r5", RDataA, 32'd5);
        checkOutput("arst_pend9", {31'b0, RPendB}, 32'd0);
        checkOutput("arst_active", {31'b0, ExcActive}, 32'd0);
        checkOutput("arst_epc", EPC, 32'd0);
        checkOutput("arst_cause", Cause, 32'd0);
        RAddrA = 5'd20; RAddrB = 5'd12;
        #1;
        checkOutput("arst_r20", RDataA, 32'd20);
        checkOutput("arst_pend12", {31'b0, RPendB}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
